shift_dut: RTL and testbench

- Fixed-amount shift/rotate unit that produces five transformed copies of one input vector in parallel.
- The five outputs are logical left, logical right, arithmetic right, rotate left and rotate right.
- All outputs are registered, with one clock of latency.
- Used as a small datapath utility block and as a reference for shift-operator semantics.

---
 rtl/shift_dut.sv | 58 +++++
 tb/tb_shift_dut.sv | 131 +++++++++++++
 2 files changed

// File: rtl/shift_dut.sv
// shift_dut: registered fixed-amount shift/rotate unit with five parallel results
module shift_dut #(
   parameter int WIDTH = 8,
   parameter int SHAMT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_vector,
   output logic [WIDTH-1:0] out_lsh,
   output logic [WIDTH-1:0] out_rsh,
   output logic [WIDTH-1:0] out_ash,
   output logic [WIDTH-1:0] out_rotl,
   output logic [WIDTH-1:0] out_rotr
);
   if (WIDTH < 2) begin : g_bad_width
      $error("shift_dut: WIDTH must be 2 or more");
   end
   if (SHAMT < 0 || SHAMT > WIDTH - 1) begin : g_bad_shamt
      $error("shift_dut: SHAMT must be in 0..WIDTH-1");
   end
   logic [WIDTH-1:0] lsh_d, rsh_d, ash_d, rotl_d, rotr_d;
   logic [WIDTH-1:0] lsh_q, rsh_q, ash_q, rotl_q, rotr_q;
   // Rotates by zero have no wrapped part, so they get their own branch to keep slices in range
   if (SHAMT == 0) begin : g_rot0
      assign rotl_d = in_vector;
      assign rotr_d = in_vector;
   end else begin : g_rot
      assign rotl_d = {in_vector[WIDTH-1-SHAMT:0], in_vector[WIDTH-1:WIDTH-SHAMT]};
      assign rotr_d = {in_vector[SHAMT-1:0], in_vector[WIDTH-1:SHAMT]};
   end
   // Shifts; the explicit cast makes the arithmetic shift sign-extend regardless of port type
   always_comb begin
      lsh_d = in_vector << SHAMT;
      rsh_d = in_vector >> SHAMT;
      ash_d = $unsigned($signed(in_vector) >>> SHAMT);
   end
   // Result registers, cleared by reset with priority over the operand
   always_ff @(posedge clk) begin
      if (rst) begin
         lsh_q  <= '0;
         rsh_q  <= '0;
         ash_q  <= '0;
         rotl_q <= '0;
         rotr_q <= '0;
      end else begin
         lsh_q  <= lsh_d;
         rsh_q  <= rsh_d;
         ash_q  <= ash_d;
         rotl_q <= rotl_d;
         rotr_q <= rotr_d;
      end
   end
   assign out_lsh  = lsh_q;
   assign out_rsh  = rsh_q;
   assign out_ash  = ash_q;
   assign out_rotl = rotl_q;
   assign out_rotr = rotr_q;
endmodule

// File: tb/tb_shift_dut.sv
// tb_shift_dut: random and directed checks of shift_dut against an arithmetic reference model
module tb_shift_dut;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] in8 = 8'h00;
   logic [15:0] in16 = 16'h0000;
   logic [7:0] o8 [4][5];
   logic [15:0] o16 [5];
   logic [15:0] exp8 [4][5];
   logic [15:0] exp16 [5];
   logic valid = 1'b0;
   int n_cmp = 0;
   int n_bad = 0;
   localparam int K8 [4] = '{1, 0, 3, 7};
   always #5 clk = ~clk;
   shift_dut #(.WIDTH(8), .SHAMT(1)) u8_1 (.clk(clk), .rst(rst), .in_vector(in8),
      .out_lsh(o8[0][0]), .out_rsh(o8[0][1]), .out_ash(o8[0][2]), .out_rotl(o8[0][3]), .out_rotr(o8[0][4]));
   shift_dut #(.WIDTH(8), .SHAMT(0)) u8_0 (.clk(clk), .rst(rst), .in_vector(in8),
      .out_lsh(o8[1][0]), .out_rsh(o8[1][1]), .out_ash(o8[1][2]), .out_rotl(o8[1][3]), .out_rotr(o8[1][4]));
   shift_dut #(.WIDTH(8), .SHAMT(3)) u8_3 (.clk(clk), .rst(rst), .in_vector(in8),
      .out_lsh(o8[2][0]), .out_rsh(o8[2][1]), .out_ash(o8[2][2]), .out_rotl(o8[2][3]), .out_rotr(o8[2][4]));
   shift_dut #(.WIDTH(8), .SHAMT(7)) u8_7 (.clk(clk), .rst(rst), .in_vector(in8),
      .out_lsh(o8[3][0]), .out_rsh(o8[3][1]), .out_ash(o8[3][2]), .out_rotl(o8[3][3]), .out_rotr(o8[3][4]));
   shift_dut #(.WIDTH(16), .SHAMT(5)) u16_5 (.clk(clk), .rst(rst), .in_vector(in16),
      .out_lsh(o16[0]), .out_rsh(o16[1]), .out_ash(o16[2]), .out_rotl(o16[3]), .out_rotr(o16[4]));
   // Reference: op 0..4 = lsh, rsh, ash, rotl, rotr of a w-bit value by k, via plain arithmetic on 32 bits
   function automatic logic [15:0] f(input int op, input logic [15:0] x, input int w, input int k);
      logic [31:0] m, v, r;
      m = (32'h1 << w) - 32'h1;
      v = {16'h0, x} & m;
      case (op)
         0: r = (v << k) & m;
         1: r = v >> k;
         2: r = (v >> k) | (v[w-1] ? (m & ~(m >> k)) : 32'h0);
         3: r = ((v << k) | (v >> (w - k))) & m;
         default: r = ((v >> k) | (v << (w - k))) & m;
      endcase
      return r[15:0];
   endfunction
   // Expected outputs after each edge, from the operand and reset present at that edge
   always @(posedge clk) begin
      valid <= valid | rst;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 5; j++)
            exp8[i][j] <= rst ? 16'h0 : f(j, {8'h0, in8}, 8, K8[i]);
      for (int j = 0; j < 5; j++)
         exp16[j] <= rst ? 16'h0 : f(j, in16, 16, 5);
   end
   // Every cycle once reset has been seen, all outputs of all instances against the model
   always @(negedge clk) begin
      if (valid) begin
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 5; j++) begin
               n_cmp++;
               if ({8'h0, o8[i][j]} !== exp8[i][j]) begin
                  n_bad++;
                  $display("FAIL model w8 inst%0d op%0d t=%0t got=%h exp=%h", i, j, $time, o8[i][j], exp8[i][j][7:0]);
               end
            end
         for (int j = 0; j < 5; j++) begin
            n_cmp++;
            if (o16[j] !== exp16[j]) begin
               n_bad++;
               $display("FAIL model w16 op%0d t=%0t got=%h exp=%h", j, $time, o16[j], exp16[j]);
            end
         end
      end
   end
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask
   task automatic lit(input string nm, input logic [39:0] e);
      for (int j = 0; j < 5; j++) begin
         n_cmp++;
         if (o8[0][j] !== e[39-8*j -: 8]) begin
            n_bad++;
            $display("FAIL %s op%0d got=%b exp=%b", nm, j, o8[0][j], e[39-8*j -: 8]);
         end
      end
   endtask
   initial begin
      rst = 1'b1;
      in8 = 8'hFF;
      in16 = 16'hFFFF;
      cyc();
      cyc();
      lit("reset", 40'h0);
      rst = 1'b0;
      in8 = 8'b11101011;
      cyc();
      lit("signed", {8'b11010110, 8'b01110101, 8'b11110101, 8'b11010111, 8'b11110101});
      in8 = 8'b11111111;
      cyc();
      lit("ones", {8'b11111110, 8'b01111111, 8'b11111111, 8'b11111111, 8'b11111111});
      in8 = 8'b01000001;
      cyc();
      lit("pos", {8'b10000010, 8'b00100000, 8'b00100000, 8'b10000010, 8'b10100000});
      in8 = 8'b10000000;
      cyc();
      lit("b2b", {8'b00000000, 8'b01000000, 8'b11000000, 8'b00000001, 8'b01000000});
      in8 = 8'h00;
      cyc();
      lit("zeros", 40'h0);
      for (int n = 0; n < 20; n++) begin
         in8 = 8'($urandom);
         in16 = 16'($urandom);
         cyc();
      end
      rst = 1'b1;
      in8 = 8'hA5;
      cyc();
      lit("midrst", 40'h0);
      rst = 1'b0;
      in8 = 8'b11101011;
      cyc();
      lit("release", {8'b11010110, 8'b01110101, 8'b11110101, 8'b11010111, 8'b11110101});
      for (int n = 0; n < 500; n++) begin
         rst = ($urandom_range(0, 15) == 0);
         in8 = (n % 37 == 0) ? 8'hFF : (n % 41 == 0) ? 8'h00 : 8'($urandom);
         in16 = 16'($urandom);
         cyc();
      end
      rst = 1'b0;
      cyc();
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
